// File: rtl/riscv_memsplit.sv
// rtl/riscv_memsplit.sv - LSU-to-bus sequencer: aligned beats, optional misaligned split
// Macro RV12_MISALIGNED_SPLIT_EN enables two-beat splitting of boundary-crossing requests.
module riscv_memsplit #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic [2:0]        size_i,
  input  logic              we_i,
  input  logic [XLEN-1:0]   d_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [XLEN-1:0]   q_o,
  output logic              mem_req_o,
  output logic [XLEN-1:0]   mem_adr_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_d_o,
  input  logic              mem_ack_i,
  input  logic              mem_err_i,
  input  logic [XLEN-1:0]   mem_q_i
);

  localparam int BPW = XLEN / 8;
  localparam int OFS = $clog2(BPW);
  localparam int NW  = OFS + 2;
`ifdef RV12_MISALIGNED_SPLIT_EN
  localparam int NB  = 2;
`else
  localparam int NB  = 1;
`endif
  localparam int BEW = NB * BPW;
  localparam int DW  = NB * XLEN;

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HWORD = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [OFS-1:0]   w_off, r_off;
  logic [NW-1:0]    w_n, r_n;
  logic             w_legal, w_bad, w_accept, w_beat_ack, w_err_nxt;
  logic             r_we, r_err;
  logic [BEW-1:0]   w_be2;
  logic [DW-1:0]    w_d2, w_data;
  logic [XLEN-1:0]  w_lo_nxt, r_lo, w_qmask, w_q;
`ifdef RV12_MISALIGNED_SPLIT_EN
  logic             w_split, r_split;
  logic [XLEN-1:0]  w_hi_nxt, r_hi, r_d_hi;
  logic [BPW-1:0]   r_be_hi;
`endif

  assign w_off      = adr_i[OFS-1:0];
  assign w_accept   = (r_state == IDLE) && req_i;
  assign w_beat_ack = mem_ack_i && ((r_state == BEAT0) || (r_state == BEAT1));

  always_comb begin
    w_n     = NW'(0);
    w_legal = 1'b1;
    case (size_i)
      SZ_BYTE:  w_n = NW'(1);
      SZ_HWORD: w_n = NW'(2);
      SZ_WORD:  w_n = NW'(4);
      SZ_DWORD: begin
        w_n     = NW'(8);
        w_legal = (XLEN == 64);
      end
      default:  w_legal = 1'b0;
    endcase
  end

`ifdef RV12_MISALIGNED_SPLIT_EN
  assign w_split = ({2'b00, w_off} + w_n) > NW'(BPW);
  assign w_bad   = !w_legal;
`else
  // Without splitting, any naturally misaligned access is rejected up front.
  assign w_bad   = !w_legal || (({2'b00, w_off} & (w_n - NW'(1))) != '0);
`endif

  assign w_be2 = ((BEW'(1) << w_n) - BEW'(1)) << w_off;
  assign w_d2  = DW'(d_i) << {w_off, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (req_i) w_state_nxt = w_bad ? RESP : BEAT0;
      BEAT0: if (mem_ack_i) begin
        w_state_nxt = RESP;
`ifdef RV12_MISALIGNED_SPLIT_EN
        if (!mem_err_i && r_split) w_state_nxt = BEAT1;
`endif
      end
      BEAT1: if (mem_ack_i) w_state_nxt = RESP;
      RESP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_err_nxt = r_err;
    if (w_accept)        w_err_nxt = w_bad;
    else if (w_beat_ack) w_err_nxt = r_err | mem_err_i;
  end

  assign w_lo_nxt = ((r_state == BEAT0) && mem_ack_i) ? mem_q_i : r_lo;
`ifdef RV12_MISALIGNED_SPLIT_EN
  assign w_hi_nxt = ((r_state == BEAT1) && mem_ack_i) ? mem_q_i : r_hi;
  assign w_data   = {w_hi_nxt, w_lo_nxt};
`else
  assign w_data   = w_lo_nxt;
`endif

  always_comb begin
    w_qmask = '0;
    for (int i = 0; i < BPW; i++) w_qmask[8*i +: 8] = (NW'(i) < r_n) ? 8'hFF : 8'h00;
  end

  assign w_q = XLEN'(w_data >> {r_off, 3'b000}) & w_qmask;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
      q_o       <= '0;
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
      mem_adr_o <= '0;
      mem_be_o  <= '0;
      mem_d_o   <= '0;
      r_off     <= '0;
      r_n       <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_lo      <= '0;
`ifdef RV12_MISALIGNED_SPLIT_EN
      r_split   <= 1'b0;
      r_hi      <= '0;
      r_be_hi   <= '0;
      r_d_hi    <= '0;
`endif
    end else begin
      ack_o     <= (w_state_nxt == RESP);
      err_o     <= (w_state_nxt == RESP) && w_err_nxt;
      q_o       <= ((w_state_nxt == RESP) && !w_err_nxt && !r_we) ? w_q : '0;
      mem_req_o <= (w_state_nxt == BEAT0) || (w_state_nxt == BEAT1);
      r_err     <= w_err_nxt;
      r_lo      <= w_lo_nxt;
`ifdef RV12_MISALIGNED_SPLIT_EN
      r_hi      <= w_hi_nxt;
`endif
      if (w_accept) begin
        r_off     <= w_off;
        r_n       <= w_n;
        r_we      <= we_i;
        mem_we_o  <= we_i;
        mem_adr_o <= {adr_i[XLEN-1:OFS], {OFS{1'b0}}};
        mem_be_o  <= w_be2[BPW-1:0];
        mem_d_o   <= w_d2[XLEN-1:0];
`ifdef RV12_MISALIGNED_SPLIT_EN
        r_split   <= w_split;
        r_be_hi   <= w_be2[BEW-1:BPW];
        r_d_hi    <= w_d2[DW-1:XLEN];
`endif
      end
`ifdef RV12_MISALIGNED_SPLIT_EN
      // Second-beat address/lanes switch on the same edge that retires beat 0.
      if ((r_state == BEAT0) && (w_state_nxt == BEAT1)) begin
        mem_adr_o <= mem_adr_o + XLEN'(BPW);
        mem_be_o  <= r_be_hi;
        mem_d_o   <= r_d_hi;
      end
`endif
    end
  end

endmodule

// File: doc/riscv_memsplit.md
# riscv_memsplit

Sequencer placed between the load/store unit and the data-side bus interface. It accepts one upstream memory request at a time and issues one or two naturally aligned XLEN-wide bus beats with byte enables. A request whose bytes cross an XLEN/8 boundary is split into two beats. For reads, the returned data is merged and right-justified before being handed back upstream.

## Interface
- XLEN, 32: data/address width, 32 or 64; BPW = XLEN/8 bytes per beat, OFS = log2(BPW) offset bits
- clk_i  in  1  clock, all state updated on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  upstream request, held with all qualifiers until ack_o
- adr_i  in  XLEN  byte address
- size_i  in  biu_size_t  BYTE/HWORD/WORD/DWORD
- we_i  in  1  1=write, 0=read
- d_i  in  XLEN  write data, right-justified
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  error, valid with ack_o
- q_o  out  XLEN  read data, right-justified, zero-extended, valid with ack_o
- mem_req_o  out  1  bus beat request, held until mem_ack_i
- mem_adr_o  out  XLEN  beat address, low OFS bits always 0
- mem_we_o  out  1  beat direction
- mem_be_o  out  BPW  byte enables
- mem_d_o  out  XLEN  beat write data, byte-lane positioned
- mem_ack_i  in  1  beat complete
- mem_err_i  in  1  beat error, valid with mem_ack_i
- mem_q_i  in  XLEN  beat read data, valid with mem_ack_i

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: if req_i=1, latch adr/size/we/d.
  - Compute off = adr_i[OFS-1:0] and n = 1/2/4/8 bytes for BYTE/HWORD/WORD/DWORD.
  - Illegal size (DWORD when XLEN=32, or any undefined encoding): set err and go to RESP with no bus beat.
  - Otherwise go to BEAT0.
- Split condition: split = (off + n > BPW). Arithmetic is OFS+2 bits wide, no wrap.
- Byte-enable mask: be2 = ((1<<n)-1) << off, 2*BPW bits wide.
- Write-data image: d2 = zero-extended d << (8*off), 2*XLEN bits wide.
- BEAT0 outputs:
  - mem_req_o=1
  - mem_adr_o = adr & ~(BPW-1)
  - mem_be_o = be2[BPW-1:0]
  - mem_d_o = d2[XLEN-1:0]
- BEAT0 on mem_ack_i: capture mem_q_i into lo.
  - If mem_err_i: set err and go to RESP; no second beat.
  - Else if split: go to BEAT1.
  - Else: go to RESP.
- BEAT1 outputs:
  - mem_adr_o = aligned adr + BPW, wrapping modulo 2^XLEN
  - mem_be_o = be2[2BPW-1:BPW]
  - mem_d_o = d2[2XLEN-1:XLEN]
- BEAT1 on mem_ack_i: capture hi and OR mem_err_i into err, then go to RESP.
- RESP:
  - ack_o=1 and err_o=err.
  - q_o = ({hi,lo} >> 8*off), masked to n bytes; q_o=0 on writes or error.
  - Next state is IDLE.
- Outputs mem_we_o, mem_adr_o, mem_be_o and mem_d_o are stable for the whole time mem_req_o is high.
- mem_ack_i while not in BEAT0/BEAT1 is ignored.

## Timing
- Reset (rst_ni=0 at an edge):
  - state=IDLE
  - ack_o=0, err_o=0, q_o=0
  - mem_req_o=0, mem_we_o=0, mem_adr_o=0, mem_be_o=0, mem_d_o=0
- Reset asserted mid-transaction abandons it. mem_req_o is low from the next edge, and a late mem_ack_i is ignored.
- Registered outputs; no combinational path from req_i to mem_req_o or from mem_ack_i to ack_o.
- Latency from req_i sampled at edge 0, with zero-wait bus:
  - Single beat: mem_req_o high in cycle 1, ack_o in cycle 2.
  - Split: mem_req_o high in cycles 1–2, ack_o in cycle 3.
  - Illegal size: ack_o in cycle 1.
- Each bus wait state adds one cycle.
- Upstream keeps req_i high through the ack_o cycle. req_i is sampled only in IDLE, so a new request in the cycle after ack_o is accepted back-to-back.
- Between BEAT0 and BEAT1, mem_req_o stays high. The address change takes effect on the edge where mem_ack_i is sampled.

## Configuration
- Macro RV12_MISALIGNED_SPLIT_EN.
- Defined: split accesses as described above.
- Undefined: a request with split=1, or with off not a multiple of n, completes as RESP with err_o=1, no bus beat, ack_o one cycle after acceptance. BEAT1 is unreachable and may be removed.

## Test plan
- XLEN=32, read BYTE at 0x1001, bus returns 0xAABBCCDD
  - one beat: adr 0x1000, be 0b0010
  - q_o=0x000000CC, ack_o in cycle 2
- Write WORD 0x11223344 at 0x1002, macro defined
  - beat0: adr 0x1000, be 0b1100, d 0x33440000
  - beat1: adr 0x1004, be 0b0011, d 0x00001122
  - ack_o in cycle 3, err_o=0
- Read HWORD at 0x1003, beats return 0xAABBCCDD then 0x11223344
  - q_o=0x000044AA
- Split read where beat0 returns mem_err_i=1
  - no beat1, ack_o=1 with err_o=1, q_o=0
- DWORD at XLEN=32
  - no mem_req_o, err_o=1 in cycle 1
- Same as the split-write test, macro undefined
  - no mem_req_o, err_o=1
- Split write with rst_ni=0 while in BEAT1
  - mem_req_o=0 next cycle, ack_o never asserted
  - next request proceeds normally
